// File: rtl/cgol_pkg.sv
// Shared types and the per-cell life rule for the Game-of-Life generation engine.
//   N_DEF       : default board edge length
//   gen_state_t : engine FSM states
//   row_t       : one board row at the default size
//   nbr_rule    : next state of a cell from its state and live-neighbour count
package cgol_pkg;

  localparam int unsigned N_DEF  = 8;
  localparam int unsigned GW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    COMMIT  = 2'd2
  } gen_state_t;

  typedef logic [N_DEF-1:0] row_t;

  // Birth on exactly 3, survival on 2 or 3
  function automatic logic nbr_rule(input logic alive, input logic [3:0] cnt);
    return (cnt == 4'd3) || (alive && (cnt == 4'd2));
  endfunction

endpackage

// File: rtl/cgol_row_rule.sv
// Combinational next-generation rule for one board row.
// Optional feature macro: CGOL_TORUS_EN (columns wrap; otherwise zero padding).
// Ports:
//   above    : row r-1 (already wrapped or zeroed by the caller)
//   mid      : row r
//   below    : row r+1 (already wrapped or zeroed by the caller)
//   row_next : next-generation value of row r
module cgol_row_rule
  import cgol_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic [N-1:0] above,
  input  logic [N-1:0] mid,
  input  logic [N-1:0] below,
  output logic [N-1:0] row_next
);

  // Rows extended by one column on each side; bit 0 is column -1, bit N+1 is column N
  logic [N+1:0] a_e;
  logic [N+1:0] m_e;
  logic [N+1:0] b_e;

`ifdef CGOL_TORUS_EN
  assign a_e = {above[0], above, above[N-1]};
  assign m_e = {mid[0],   mid,   mid[N-1]};
  assign b_e = {below[0], below, below[N-1]};
`else
  assign a_e = {1'b0, above, 1'b0};
  assign m_e = {1'b0, mid,   1'b0};
  assign b_e = {1'b0, below, 1'b0};
`endif

  // Column c sits at extended index c+1; neighbours span c..c+2
  for (genvar c = 0; c < N; c++) begin : g_col
    logic [3:0] cnt;
    assign cnt = 4'(a_e[c]) + 4'(a_e[c+1]) + 4'(a_e[c+2])
               + 4'(m_e[c])                + 4'(m_e[c+2])
               + 4'(b_e[c]) + 4'(b_e[c+1]) + 4'(b_e[c+2]);
    assign row_next[c] = nbr_rule(m_e[c+1], cnt);
  end

endmodule

// File: rtl/cgol_gen_engine.sv
// Game-of-Life generation engine: holds an NxN board, computes the next
// generation one row per cycle on request, then commits it atomically.
// Optional feature macro: CGOL_TORUS_EN (toroidal board; otherwise dead edges).
// Ports:
//   ph1, ph2  : non-overlapping two-phase clock (master on ph1, slave on ph2)
//   reset     : synchronous active-low reset, sampled on ph1
//   load_en, load_row, load_data : write one row of the committed board (IDLE only)
//   step_req  : request one generation step (IDLE only)
//   busy      : high while computing or committing
//   gen_done  : one-cycle pulse in the commit cycle
//   rd_row, rd_data : combinational read of the committed board
//   gen_count : generations committed since reset (wraps)
module cgol_gen_engine
  import cgol_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned GW = GW_DEF
) (
  input  logic                 ph1,
  input  logic                 ph2,
  input  logic                 reset,
  input  logic                 load_en,
  input  logic [$clog2(N)-1:0] load_row,
  input  logic [N-1:0]         load_data,
  input  logic                 step_req,
  output logic                 busy,
  output logic                 gen_done,
  input  logic [$clog2(N)-1:0] rd_row,
  output logic [N-1:0]         rd_data,
  output logic [GW-1:0]        gen_count
);

  localparam int unsigned RW = $clog2(N);

  typedef logic [N-1:0][N-1:0] board_t;

  // _d: next-state logic, _m: ph1 master, _q: ph2 slave (architectural state)
  gen_state_t    state_d, state_m, state_q;
  logic [RW-1:0] r_d, r_m, r_q;
  board_t        cur_d, cur_m, cur_q;
  board_t        nxt_d, nxt_m, nxt_q;
  logic [GW-1:0] cnt_d, cnt_m, cnt_q;
  logic          busy_d, busy_m, busy_q;
  logic          done_d, done_m, done_q;

  logic [N-1:0]  wrap_top, wrap_bot;
  logic [N-1:0]  above, below, row_new;
  logic          last_row;

  // Rows seen across the top and bottom edges
`ifdef CGOL_TORUS_EN
  assign wrap_top = cur_q[N-1];
  assign wrap_bot = cur_q[0];
`else
  assign wrap_top = '0;
  assign wrap_bot = '0;
`endif

  assign last_row = (r_q == RW'(N-1));
  assign above    = (r_q == '0) ? wrap_top : cur_q[r_q - RW'(1)];
  assign below    = last_row    ? wrap_bot : cur_q[r_q + RW'(1)];

  cgol_row_rule #(.N(N)) u_row_rule (
    .above    (above),
    .mid      (cur_q[r_q]),
    .below    (below),
    .row_next (row_new)
  );

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    busy_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Load has priority; a simultaneous step request is dropped
        if (load_en) begin
          if (32'(load_row) < N) cur_d[load_row] = load_data;
        end else if (step_req) begin
          r_d     = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        nxt_d[r_q] = row_new;
        r_d        = r_q + RW'(1);
        if (last_row) begin
          state_d = COMMIT;
          done_d  = 1'b1;  // registered so the pulse coincides with COMMIT
        end
      end
      COMMIT: begin
        cur_d   = nxt_q;
        cnt_d   = cnt_q + GW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // ph1 master: captures next state (or reset values) as ph1 closes
  always_ff @(negedge ph1) begin
    if (!reset) begin
      state_m <= IDLE;
      r_m     <= '0;
      cur_m   <= '0;
      nxt_m   <= '0;
      cnt_m   <= '0;
      busy_m  <= 1'b0;
      done_m  <= 1'b0;
    end else begin
      state_m <= state_d;
      r_m     <= r_d;
      cur_m   <= cur_d;
      nxt_m   <= nxt_d;
      cnt_m   <= cnt_d;
      busy_m  <= busy_d;
      done_m  <= done_d;
    end
  end

  // ph2 slave: master is stable during ph2, so the slave follows it from ph2 rise
  always_ff @(posedge ph2) begin
    state_q <= state_m;
    r_q     <= r_m;
    cur_q   <= cur_m;
    nxt_q   <= nxt_m;
    cnt_q   <= cnt_m;
    busy_q  <= busy_m;
    done_q  <= done_m;
  end

  assign busy      = busy_q;
  assign gen_done  = done_q;
  assign gen_count = cnt_q;
  assign rd_data   = (32'(rd_row) < N) ? cur_q[rd_row] : '0;

endmodule
